// File: rtl/traffic_scheduler.sv
// traffic_scheduler: two-road intersection controller with left-turn phases,
// pedestrian extension on road B green, emergency all-red hold and run-time
// programmable phase durations.
//
// Ports
//   clk       clock; all state changes on the rising edge
//   en        synchronous active-low reset
//   tick      one-cycle countdown strobe
//   cfg_we    duration write strobe
//   cfg_sel   0=GA 1=YA 2=LA 3=GB 4=YB 5=LB (6,7 ignored)
//   cfg_data  binary duration, clamped to 1..99
//   ped_req   pedestrian request pulse (crossing road A)
//   emg       emergency all-red hold
//   lampa     road A lamps, one-hot {red, yellow, green, left}
//   lampb     road B lamps, same encoding
//   acount    road A remaining time, BCD, saturates at 99
//   bcount    road B remaining time, BCD, saturates at 99
//   ped_walk  walk signal, only during a served B green
//   phase     current state code
module traffic_scheduler #(
   parameter int DEF_GA  = 40,
   parameter int DEF_GB  = 30,
   parameter int DEF_Y   = 5,
   parameter int DEF_L   = 15,
   parameter int PED_MIN = 20
) (
   input  logic       clk,
   input  logic       en,
   input  logic       tick,
   input  logic       cfg_we,
   input  logic [2:0] cfg_sel,
   input  logic [6:0] cfg_data,
   input  logic       ped_req,
   input  logic       emg,
   output logic [3:0] lampa,
   output logic [3:0] lampb,
   output logic [7:0] acount,
   output logic [7:0] bcount,
   output logic       ped_walk,
   output logic [3:0] phase
);

   typedef enum logic [3:0] {
      INIT = 4'd0, A_G = 4'd1, A_Y1 = 4'd2, A_L = 4'd3, A_Y2 = 4'd4,
      B_G = 4'd5, B_Y1 = 4'd6, B_L = 4'd7, B_Y2 = 4'd8, ALLRED = 4'd9
   } state_t;

   localparam logic [3:0] RED = 4'b1000, YEL = 4'b0100, GRN = 4'b0010, LFT = 4'b0001;

   state_t     state, state_n;
   logic [6:0] ga, ya, la, gb, yb, lb;
   logic [6:0] wdat, gb_eff;
   logic [8:0] acnt, bcnt, acnt_n, bcnt_n, act;
   logic       pend, pend_n, pend_eff, walk, walk_n;
   logic       a_side, go_ag, go_bg;

   function automatic logic [8:0] ext(input logic [6:0] v);
      return {2'b00, v};
   endfunction

   function automatic logic [7:0] to_bcd(input logic [8:0] v);
      logic [6:0] s;
      logic [3:0] t, u;
      s = (v > 9'd99) ? 7'd99 : v[6:0];
      t = 4'(s / 7'd10);
      u = 4'(s - 7'(t) * 7'd10);
      return {t, u};
   endfunction

   assign wdat = (cfg_data == 7'd0) ? 7'd1 : (cfg_data > 7'd99) ? 7'd99 : cfg_data;

   always_comb begin
      state_n  = state;
      acnt_n   = acnt;
      bcnt_n   = bcnt;
      go_ag    = 1'b0;
      go_bg    = 1'b0;
      // a request arriving in the same cycle as B_G entry is served immediately
      pend_eff = pend | (ped_req & (state != B_G));
      pend_n   = pend_eff;
      walk_n   = walk;
      gb_eff   = (pend_eff && (gb < 7'(PED_MIN))) ? 7'(PED_MIN) : gb;
      a_side   = (state == A_G) || (state == A_Y1) || (state == A_L) || (state == A_Y2);
      act      = a_side ? acnt : bcnt;

      if (tick) begin
         if (acnt != 9'd0) acnt_n = acnt - 9'd1;
         if (bcnt != 9'd0) bcnt_n = bcnt - 9'd1;
      end

      if (emg) begin
         state_n = ALLRED;
         acnt_n  = 9'd0;
         bcnt_n  = 9'd0;
         walk_n  = 1'b0;
      end else begin
         case (state)
            INIT, ALLRED: go_ag = 1'b1;
            default:
               if (tick && act == 9'd1) begin
                  case (state)
                     A_G:     begin state_n = A_Y1; acnt_n = ext(ya); end
                     A_Y1:    begin state_n = A_L;  acnt_n = ext(la); end
                     A_L:     begin state_n = A_Y2; acnt_n = ext(ya); end
                     A_Y2:    go_bg = 1'b1;
                     B_G:     begin state_n = B_Y1; bcnt_n = ext(yb); end
                     B_Y1:    begin state_n = B_L;  bcnt_n = ext(lb); end
                     B_L:     begin state_n = B_Y2; bcnt_n = ext(yb); end
                     B_Y2:    go_ag = 1'b1;
                     default: state_n = INIT;
                  endcase
               end
         endcase
         // green entries reload both roads: the red road waits G+2Y+L
         if (go_ag) begin
            state_n = A_G;
            acnt_n  = ext(ga);
            bcnt_n  = ext(ga) + (ext(ya) << 1) + ext(la);
            walk_n  = 1'b0;
         end
         if (go_bg) begin
            state_n = B_G;
            bcnt_n  = ext(gb_eff);
            acnt_n  = ext(gb_eff) + (ext(yb) << 1) + ext(lb);
            walk_n  = pend_eff;
            pend_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!en) begin
         state <= INIT;
         acnt  <= '0;
         bcnt  <= '0;
         pend  <= 1'b0;
         walk  <= 1'b0;
         ga    <= 7'(DEF_GA);
         gb    <= 7'(DEF_GB);
         ya    <= 7'(DEF_Y);
         yb    <= 7'(DEF_Y);
         la    <= 7'(DEF_L);
         lb    <= 7'(DEF_L);
      end else begin
         state <= state_n;
         acnt  <= acnt_n;
         bcnt  <= bcnt_n;
         pend  <= pend_n;
         walk  <= walk_n;
         if (cfg_we) begin
            case (cfg_sel)
               3'd0:    ga <= wdat;
               3'd1:    ya <= wdat;
               3'd2:    la <= wdat;
               3'd3:    gb <= wdat;
               3'd4:    yb <= wdat;
               3'd5:    lb <= wdat;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      lampa = RED;
      lampb = RED;
      case (state)
         A_G:        lampa = GRN;
         A_Y1, A_Y2: lampa = YEL;
         A_L:        lampa = LFT;
         B_G:        lampb = GRN;
         B_Y1, B_Y2: lampb = YEL;
         B_L:        lampb = LFT;
         default:    ;
      endcase
   end

   assign acount   = (state == ALLRED) ? 8'h00 : to_bcd(acnt);
   assign bcount   = (state == ALLRED) ? 8'h00 : to_bcd(bcnt);
   assign ped_walk = walk && (state == B_G);
   assign phase    = state;

endmodule
